// File: rtl/flit_receiver.sv
// Byte-link receive end: deserialises bytes into FLIT_BYTES-wide flits, checks the
// trailing XOR checksum, buffers one good flit and counts dropped (bad/stalled) flits.
module flit_receiver #(
    parameter int unsigned FLIT_BYTES     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    byte_valid_i,
    input  logic [7:0]              byte_i,
    output logic                    byte_ready_o,
    output logic                    flit_valid_o,
    output logic [FLIT_BYTES*8-1:0] flit_o,
    input  logic                    flit_ready_i,
    output logic                    crc_err_o,
    output logic                    timeout_o,
    output logic [7:0]              err_cnt_o
);

    localparam int unsigned IW = $clog2(FLIT_BYTES);
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(FLIT_BYTES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;

    logic [1:0]              r_state;
    logic                    r_alive;
    logic [IW-1:0]           r_idx;
    logic [7:0]              r_xor;
    logic [CW-1:0]           r_idle;
    logic [FLIT_BYTES*8-1:0] r_flit;
    logic                    r_crc_err;
    logic                    r_timeout;
    logic [7:0]              r_err_cnt;

    logic w_accept;
    logic w_last;
    logic w_xor_ok;
    logic w_stall;
    logic w_err;

    // r_alive holds ready low while in reset and releases it on the first clock after.
    assign byte_ready_o = r_alive & (r_state != S_HOLD);
    assign flit_valid_o = (r_state == S_HOLD);
    assign flit_o       = r_flit;
    assign crc_err_o    = r_crc_err;
    assign timeout_o    = r_timeout;
    assign err_cnt_o    = r_err_cnt;

    assign w_accept = byte_valid_i & byte_ready_o;
    assign w_last   = w_accept & (r_idx == LAST_IDX);
    assign w_xor_ok = (r_xor == byte_i);
    assign w_stall  = (r_state == S_COLLECT) & ~w_accept & (r_idle == TO_LAST);
    assign w_err    = (w_last & ~w_xor_ok) | w_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_alive   <= 1'b0;
            r_idx     <= '0;
            r_xor     <= '0;
            r_idle    <= '0;
            r_flit    <= '0;
            r_crc_err <= 1'b0;
            r_timeout <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_alive   <= 1'b1;
            r_crc_err <= 1'b0;
            r_timeout <= 1'b0;
            if (r_state == S_HOLD) begin
                if (flit_ready_i) begin
                    r_state <= S_IDLE;
                end
            end else if (w_accept) begin
                r_flit[r_idx*8 +: 8] <= byte_i;
                r_idle <= '0;
                if (w_last) begin
                    r_idx <= '0;
                    r_xor <= '0;
                    if (w_xor_ok) begin
                        r_state <= S_HOLD;
                    end else begin
                        r_state   <= S_IDLE;
                        r_crc_err <= 1'b1;
                    end
                end else begin
                    r_idx   <= r_idx + 1'b1;
                    r_xor   <= r_xor ^ byte_i;
                    r_state <= S_COLLECT;
                end
            end else if (r_state == S_COLLECT) begin
                if (w_stall) begin
                    r_state   <= S_IDLE;
                    r_timeout <= 1'b1;
                    r_idx     <= '0;
                    r_xor     <= '0;
                    r_idle    <= '0;
                end else begin
                    r_idle <= r_idle + 1'b1;
                end
            end
            if (w_err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_flit_receiver.sv
// Directed bench for flit_receiver: expected flits are queued as stimulus is driven
// and compared when the receiver presents them.
`timescale 1ns/1ps
module tb_flit_receiver;

    localparam int unsigned FB = 8;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          byte_valid_i;
    logic [7:0]    byte_i;
    logic          byte_ready_o;
    logic          flit_valid_o;
    logic [FB*8-1:0] flit_o;
    logic          flit_ready_i;
    logic          crc_err_o;
    logic          timeout_o;
    logic [7:0]    err_cnt_o;

    int n_checks = 0;
    int n_err    = 0;
    logic [FB*8-1:0] exp_q[$];

    flit_receiver #(.FLIT_BYTES(FB), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .byte_valid_i (byte_valid_i),
        .byte_i       (byte_i),
        .byte_ready_o (byte_ready_o),
        .flit_valid_o (flit_valid_o),
        .flit_o       (flit_o),
        .flit_ready_i (flit_ready_i),
        .crc_err_o    (crc_err_o),
        .timeout_o    (timeout_o),
        .err_cnt_o    (err_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Appends the XOR of the payload bytes as the checksum byte.
    function automatic logic [FB*8-1:0] make_flit(input logic [(FB-1)*8-1:0] payload);
        logic [7:0] x;
        x = '0;
        for (int i = 0; i < FB - 1; i++) x = x ^ payload[i*8 +: 8];
        return {x, payload};
    endfunction

    // Drives all bytes back to back; returns at the negedge one clock after the last byte.
    task automatic drive_flit(input logic [FB*8-1:0] f, input bit good);
        for (int i = 0; i < FB; i++) begin
            @(negedge clk);
            byte_valid_i = 1'b1;
            byte_i       = f[i*8 +: 8];
        end
        if (good) exp_q.push_back(f);
        @(negedge clk);
        byte_valid_i = 1'b0;
    endtask

    task automatic pop_cmp(input string tag);
        logic [FB*8-1:0] e;
        chk({tag, "_sb_nonempty"}, 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(tag, flit_o, e);
        end
    endtask

    initial begin
        logic [FB*8-1:0] good1;
        logic [FB*8-1:0] good2;
        logic [FB*8-1:0] bad;
        bit seen;

        good1 = 64'h0007060504030201;
        good2 = make_flit(56'h70605040302010);
        rst_n = 1'b0;
        byte_valid_i = 1'b0;
        byte_i = '0;
        flit_ready_i = 1'b1;

        // 1: reset
        repeat (2) @(negedge clk);
        chk("rst_ready", byte_ready_o, 1'b0);
        chk("rst_valid", flit_valid_o, 1'b0);
        chk("rst_flit", flit_o, '0);
        chk("rst_crc", crc_err_o, 1'b0);
        chk("rst_to", timeout_o, 1'b0);
        chk("rst_cnt", err_cnt_o, 8'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", byte_ready_o, 1'b1);

        // 2: good flit with sink ready
        drive_flit(good1, 1'b1);
        chk("t2_valid", flit_valid_o, 1'b1);
        pop_cmp("t2_flit");
        chk("t2_crc", crc_err_o, 1'b0);
        chk("t2_to", timeout_o, 1'b0);
        @(negedge clk);
        chk("t2_valid_drop", flit_valid_o, 1'b0);
        chk("t2_ready", byte_ready_o, 1'b1);

        // 3: backpressure
        flit_ready_i = 1'b0;
        drive_flit(good1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            chk("t3_valid_hold", flit_valid_o, 1'b1);
            chk("t3_flit_hold", flit_o, exp_q.size() > 0 ? exp_q[0] : '0);
            chk("t3_ready_low", byte_ready_o, 1'b0);
            @(negedge clk);
        end
        pop_cmp("t3_flit");
        flit_ready_i = 1'b1;
        @(negedge clk);
        chk("t3_valid_drop", flit_valid_o, 1'b0);
        chk("t3_ready", byte_ready_o, 1'b1);

        // 4: bad checksum
        bad = good1;
        bad[63:56] = 8'hFF;
        drive_flit(bad, 1'b0);
        chk("t4_crc", crc_err_o, 1'b1);
        chk("t4_valid", flit_valid_o, 1'b0);
        chk("t4_cnt", err_cnt_o, 8'd1);
        @(negedge clk);
        chk("t4_crc_pulse", crc_err_o, 1'b0);
        chk("t4_valid2", flit_valid_o, 1'b0);

        // 5: timeout after 3 bytes
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            byte_valid_i = 1'b1;
            byte_i = 8'hA0 + 8'(i);
        end
        @(negedge clk);
        byte_valid_i = 1'b0;
        for (int i = 0; i < TO - 1; i++) begin
            chk("t5_no_early_to", timeout_o, 1'b0);
            @(negedge clk);
        end
        seen = 1'b0;
        for (int i = 0; i < 3 && !seen; i++) begin
            if (timeout_o) seen = 1'b1;
            else @(negedge clk);
        end
        chk("t5_to_seen", seen, 1'b1);
        chk("t5_cnt", err_cnt_o, 8'd2);
        chk("t5_crc", crc_err_o, 1'b0);
        @(negedge clk);
        chk("t5_to_pulse", timeout_o, 1'b0);
        drive_flit(good1, 1'b1);
        chk("t5_valid", flit_valid_o, 1'b1);
        pop_cmp("t5_flit");
        @(negedge clk);

        // 6: reset mid-flit
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            byte_valid_i = 1'b1;
            byte_i = 8'hC0 + 8'(i);
        end
        @(negedge clk);
        byte_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_cnt", err_cnt_o, 8'd0);
        chk("t6_ready", byte_ready_o, 1'b0);
        chk("t6_valid", flit_valid_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_ready_rel", byte_ready_o, 1'b1);
        drive_flit(good2, 1'b1);
        chk("t6_valid2", flit_valid_o, 1'b1);
        pop_cmp("t6_flit");
        chk("t6_cnt2", err_cnt_o, 8'd0);
        @(negedge clk);

        // error counter saturation
        for (int n = 0; n < 256; n++) begin
            bad = make_flit({$urandom, $urandom}[55:0]);
            bad[63:56] = bad[63:56] ^ 8'h01;
            drive_flit(bad, 1'b0);
            if (n == 254) chk("sat_254", err_cnt_o, 8'd255);
        end
        chk("sat_cnt", err_cnt_o, 8'd255);
        chk("sat_valid", flit_valid_o, 1'b0);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
